// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, op codes,
// FSM state encoding and small op classification helpers.
package mem_access_pkg;

  localparam int          REG_BUS      = 32;
  localparam int          REG_ADDR_BUS = 5;
  localparam logic        RST_ENABLE   = 1'b1;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_ACCESS = 2'd1,
    MA_DONE   = 2'd2
  } ma_state_e;

  // Codes outside LB..SW behave as NONE.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic is_load_op(input logic [3:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Big-endian byte-lane steering: byte enables, replicated store data,
// extended load data and the alignment check for one access.
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [3:0]         op,
  input  logic [1:0]         addr_lo,
  input  logic [REG_BUS-1:0] sdata,
  input  logic [REG_BUS-1:0] rdata,
  output logic [3:0]         sel,
  output logic [REG_BUS-1:0] wdata_lanes,
  output logic [REG_BUS-1:0] load_data,
  output logic               misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Lane 0 (offset 0) is the most significant byte of the bus word.
  always_comb begin
    rbyte       = rdata[31:24];
    rhalf       = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    sel         = 4'b0000;
    wdata_lanes = ZERO_WORD;
    load_data   = ZERO_WORD;
    misaligned  = 1'b0;
    case (addr_lo)
      2'd0:    rbyte = rdata[31:24];
      2'd1:    rbyte = rdata[23:16];
      2'd2:    rbyte = rdata[15:8];
      default: rbyte = rdata[7:0];
    endcase
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        sel         = 4'b1000 >> addr_lo;
        wdata_lanes = {4{sdata[7:0]}};
        load_data   = (op == MEM_OP_LB) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        sel         = addr_lo[1] ? 4'b0011 : 4'b1100;
        wdata_lanes = {2{sdata[15:0]}};
        load_data   = (op == MEM_OP_LH) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
        misaligned  = addr_lo[0];
      end
      MEM_OP_LW, MEM_OP_SW: begin
        sel         = 4'b1111;
        wdata_lanes = sdata;
        load_data   = rdata;
        misaligned  = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one outstanding req/ack bus transaction at a time,
// stalls upstream while it runs, and registers the write-back fields.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_BUS-1:0] mem_wd_i,
  input  logic                    mem_wreg_i,
  input  logic [REG_BUS-1:0]      mem_wdata_i,
  input  logic [3:0]              mem_op_i,
  input  logic [REG_BUS-1:0]      mem_addr_i,
  input  logic [REG_BUS-1:0]      mem_sdata_i,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [REG_BUS-1:0]      bus_addr_o,
  output logic [3:0]              bus_sel_o,
  output logic [REG_BUS-1:0]      bus_wdata_o,
  input  logic [REG_BUS-1:0]      bus_rdata_i,
  input  logic                    bus_ack_i,
  output logic                    stallreq_o,
  output logic [REG_ADDR_BUS-1:0] wb_wd_o,
  output logic                    wb_wreg_o,
  output logic [REG_BUS-1:0]      wb_wdata_o,
  output logic                    align_err_o,
  output logic                    bus_err_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  ma_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic               abort;
  logic [3:0]         op_q;
  logic [1:0]         addr_lo_q;
  logic [REG_BUS-1:0] load_q;

  logic [3:0]         lane_op;
  logic [1:0]         lane_addr;
  logic [3:0]         sel;
  logic [REG_BUS-1:0] wdata_lanes;
  logic [REG_BUS-1:0] load_data;
  logic               misaligned;

  // In IDLE the lane logic looks at the incoming op; afterwards at the latched one.
  assign lane_op   = (state == MA_IDLE) ? mem_op_i : op_q;
  assign lane_addr = (state == MA_IDLE) ? mem_addr_i[1:0] : addr_lo_q;

  mem_lane u_lane (
    .op          (lane_op),
    .addr_lo     (lane_addr),
    .sdata       (mem_sdata_i),
    .rdata       (bus_rdata_i),
    .sel         (sel),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  // Stall upstream from the cycle an aligned access is seen until DONE.
  always_comb begin
    stallreq_o = 1'b0;
    if (rst != RST_ENABLE) begin
      case (state)
        MA_IDLE:   stallreq_o = is_mem_op(mem_op_i) && !misaligned;
        MA_ACCESS: stallreq_o = 1'b1;
        default:   stallreq_o = 1'b0;
      endcase
    end
  end

  // Access FSM with registered bus and write-back outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state       <= MA_IDLE;
      cnt         <= '0;
      abort       <= 1'b0;
      op_q        <= 4'h0;
      addr_lo_q   <= 2'b00;
      load_q      <= ZERO_WORD;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= ZERO_WORD;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= ZERO_WORD;
      wb_wd_o     <= '0;
      wb_wreg_o   <= 1'b0;
      wb_wdata_o  <= ZERO_WORD;
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      align_err_o <= 1'b0;
      bus_err_o   <= 1'b0;
      case (state)
        MA_IDLE: begin
          if (!is_mem_op(mem_op_i)) begin
            wb_wd_o    <= mem_wd_i;
            wb_wreg_o  <= mem_wreg_i;
            wb_wdata_o <= mem_wdata_i;
          end else if (misaligned) begin
            wb_wreg_o   <= 1'b0;
            align_err_o <= 1'b1;
          end else begin
            op_q        <= mem_op_i;
            addr_lo_q   <= mem_addr_i[1:0];
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store_op(mem_op_i);
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_sel_o   <= sel;
            bus_wdata_o <= wdata_lanes;
            cnt         <= '0;
            abort       <= 1'b0;
            wb_wreg_o   <= 1'b0;
            state       <= MA_ACCESS;
          end
        end
        MA_ACCESS: begin
          if (bus_ack_i) begin
            load_q    <= load_data;
            bus_req_o <= 1'b0;
            state     <= MA_DONE;
          end else if (cnt == CNT_LAST) begin
            abort     <= 1'b1;
            bus_req_o <= 1'b0;
            state     <= MA_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MA_DONE: begin
          wb_wd_o    <= mem_wd_i;
          wb_wreg_o  <= mem_wreg_i & is_load_op(op_q) & ~abort;
          wb_wdata_o <= is_load_op(op_q) ? load_q : mem_wdata_i;
          bus_err_o  <= abort;
          state      <= MA_IDLE;
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases followed by random
// transactions compared against a byte-level reference model.
module tb_mem_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_sdata_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        stallreq_o;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        align_err_o;
  logic        bus_err_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wd_i    (mem_wd_i),
    .mem_wreg_i  (mem_wreg_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_op_i    (mem_op_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sdata_i (mem_sdata_i),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_sel_o   (bus_sel_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ack_i   (bus_ack_i),
    .stallreq_o  (stallreq_o),
    .wb_wd_o     (wb_wd_o),
    .wb_wreg_o   (wb_wreg_o),
    .wb_wdata_o  (wb_wdata_o),
    .align_err_o (align_err_o),
    .bus_err_o   (bus_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: kind 0 = pass-through, 1 = misaligned, 2 = bus access.
  function automatic void model(input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                output int kind, output bit ld, output logic [3:0] sel,
                                output logic [31:0] wlanes, output logic [31:0] ldata);
    int size;
    int off;
    bit sgn;
    logic [31:0] v;
    size = 0; ld = 1'b0; sgn = 1'b0;
    case (op)
      4'd1: begin size = 1; ld = 1'b1; sgn = 1'b1; end
      4'd2: begin size = 1; ld = 1'b1; end
      4'd3: begin size = 2; ld = 1'b1; sgn = 1'b1; end
      4'd4: begin size = 2; ld = 1'b1; end
      4'd5: begin size = 4; ld = 1'b1; end
      4'd6: size = 1;
      4'd7: size = 2;
      4'd8: size = 4;
      default: size = 0;
    endcase
    sel = 4'b0000; wlanes = 32'h0; ldata = 32'h0; v = 32'h0;
    off = int'(addr[1:0]);
    if (size == 0) kind = 0;
    else if ((off % size) != 0) kind = 1;
    else begin
      kind = 2;
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) begin
          sel[3-i] = 1'b1;
          v = (v << 8) | ((rdata >> (24 - 8*i)) & 32'hFF);
        end
        wlanes = wlanes | (((sdata >> (8*(size - 1 - (i % size)))) & 32'hFF) << (24 - 8*i));
      end
      if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
      ldata = v;
    end
  endfunction

  task automatic run_txn(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input int ack_dly);
    int kind;
    bit ld;
    bit ab;
    bit stall_ok;
    logic [3:0] sel;
    logic [31:0] wl, ldat;
    int acc, n_exp;
    model(op, addr, sdata, rdata, kind, ld, sel, wl, ldat);
    mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sdata;
    mem_wd_i = wd; mem_wreg_i = wreg; mem_wdata_i = wdata;
    bus_ack_i = (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    bus_rdata_i = $urandom;
    #1;
    chk({nm, ".stall_idle"}, 32'(stallreq_o), 32'(kind == 2));
    chk({nm, ".req_idle"}, 32'(bus_req_o), 32'h0);
    if (kind == 0) begin
      tick();
      chk({nm, ".wb_wd"}, 32'(wb_wd_o), 32'(wd));
      chk({nm, ".wb_wreg"}, 32'(wb_wreg_o), 32'(wreg));
      chk({nm, ".wb_wdata"}, wb_wdata_o, wdata);
      chk({nm, ".errs"}, {30'h0, align_err_o, bus_err_o}, 32'h0);
    end else if (kind == 1) begin
      tick();
      chk({nm, ".align_err"}, 32'(align_err_o), 32'h1);
      chk({nm, ".wb_wreg"}, 32'(wb_wreg_o), 32'h0);
      chk({nm, ".req"}, 32'(bus_req_o), 32'h0);
    end else begin
      tick();
      chk({nm, ".req"}, 32'(bus_req_o), 32'h1);
      chk({nm, ".addr"}, bus_addr_o, {addr[31:2], 2'b00});
      chk({nm, ".sel"}, 32'(bus_sel_o), 32'(sel));
      chk({nm, ".we"}, 32'(bus_we_o), 32'(!ld));
      if (!ld) chk({nm, ".wdata"}, bus_wdata_o, wl);
      chk({nm, ".wb_wreg_bubble"}, 32'(wb_wreg_o), 32'h0);
      chk({nm, ".errs"}, {30'h0, align_err_o, bus_err_o}, 32'h0);
      acc = 0;
      stall_ok = 1'b1;
      while (bus_req_o === 1'b1 && acc < 3*TO) begin
        bus_ack_i   = (acc == ack_dly);
        bus_rdata_i = (acc == ack_dly) ? rdata : $urandom;
        #1;
        if (stallreq_o !== 1'b1) stall_ok = 1'b0;
        acc++;
        tick();
      end
      bus_ack_i = 1'b0;
      bus_rdata_i = $urandom;
      n_exp = (ack_dly < TO) ? ack_dly + 1 : TO;
      ab = (ack_dly >= TO);
      chk({nm, ".access_cycles"}, 32'(acc), 32'(n_exp));
      chk({nm, ".stall_access"}, 32'(stall_ok), 32'h1);
      #1;
      chk({nm, ".stall_done"}, 32'(stallreq_o), 32'h0);
      tick();
      chk({nm, ".wb_wd"}, 32'(wb_wd_o), 32'(wd));
      chk({nm, ".wb_wreg"}, 32'(wb_wreg_o), 32'(wreg & ld & !ab));
      if (!ld) chk({nm, ".wb_wdata"}, wb_wdata_o, wdata);
      else if (!ab) chk({nm, ".wb_wdata"}, wb_wdata_o, ldat);
      chk({nm, ".bus_err"}, 32'(bus_err_o), 32'(ab));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem_wd_i = '0; mem_wreg_i = 1'b0; mem_wdata_i = '0; mem_op_i = '0;
    mem_addr_i = '0; mem_sdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
    tick();
    tick();
    chk("reset.req", 32'(bus_req_o), 32'h0);
    chk("reset.stall", 32'(stallreq_o), 32'h0);
    chk("reset.bus", bus_addr_o | bus_wdata_o | 32'(bus_sel_o) | 32'(bus_we_o), 32'h0);
    chk("reset.wb", wb_wdata_o | 32'(wb_wd_o) | 32'(wb_wreg_o), 32'h0);
    chk("reset.errs", {30'h0, align_err_o, bus_err_o}, 32'h0);
    rst = 1'b0;

    run_txn("none", 4'd0, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234_5678, 0);
    run_txn("lb", 4'd1, 32'h1001, 32'h0, 32'h11F0_3344, 5'd7, 1'b1, 32'hDEAD_BEEF, 2);
    chk("lb.const", wb_wdata_o, 32'hFFFF_FFF0);
    run_txn("lbu", 4'd2, 32'h1001, 32'h0, 32'h11F0_3344, 5'd7, 1'b1, 32'hDEAD_BEEF, 2);
    chk("lbu.const", wb_wdata_o, 32'h0000_00F0);
    run_txn("sh", 4'd7, 32'h2002, 32'hAAAA_1234, 32'h0, 5'd3, 1'b1, 32'h0, 0);
    run_txn("lw_mis", 4'd5, 32'h3002, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0, 0);
    run_txn("lw_to", 4'd5, 32'h4000, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0, 99);
    run_txn("after_to", 4'd0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b0, 32'hCAFE_0001, 0);

    // Reset in the middle of an access.
    mem_op_i = 4'd5; mem_addr_i = 32'h5000; mem_wd_i = 5'd4; mem_wreg_i = 1'b1;
    bus_ack_i = 1'b0;
    tick();
    chk("rst_mid.req_before", 32'(bus_req_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.req", 32'(bus_req_o), 32'h0);
    chk("rst_mid.stall", 32'(stallreq_o), 32'h0);
    chk("rst_mid.wb", wb_wdata_o | 32'(wb_wd_o) | 32'(wb_wreg_o), 32'h0);
    tick();
    rst = 1'b0;
    run_txn("rst_none", 4'd0, 32'h0, 32'h0, 32'h0, 5'd17, 1'b1, 32'h0BAD_F00D, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn($sformatf("rnd%0d", n), 4'($urandom_range(0, 10)), a, $urandom, $urandom,
              5'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
